// File: rtl/sevenseg_seq_monitor.sv
// sevenseg_seq_monitor
//   Receive-side checker for the 14-step active-low 7-segment animation bus.
//   Each sampled pattern is debounced. The monitor locks on the step-0 pattern (FE),
//   then tracks the step index by context, because several patterns repeat
//   within the sequence. It reports lock, current step, completed cycles,
//   sequence errors and stalls.
//
//   Optional build macro: SEVENSEG_MON_SYNC_EN adds a 2-flop synchronizer on seg_in
//   (reset value 8'hFF) ahead of the debounce.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_en    one-cycle sampling strobe; all non-reset state advances only when high
//   seg_in       8-bit active-low segment bus
//   locked       high while tracking
//   step_idx     tracked step 0..13, 0 when not locked
//   cycle_done   one-cycle pulse on each step-13 -> step-0 transition
//   seq_err      one-cycle pulse on a sequence error
//   stall        one-cycle pulse on a tracking timeout
//   cycle_count  completed cycles, saturating
//   err_count    sequence errors, saturating
module sevenseg_seq_monitor #(
  parameter int unsigned STABLE_SAMPLES  = 2,
  parameter int unsigned TIMEOUT_SAMPLES = 64,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [7:0]       seg_in,
  output logic             locked,
  output logic [3:0]       step_idx,
  output logic             cycle_done,
  output logic             seq_err,
  output logic             stall,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StTrack, StError} state_e;

  localparam logic [3:0]  StableMax   = 4'(STABLE_SAMPLES);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_SAMPLES - 1);
  localparam logic [7:0]  PatStart    = 8'hFE;

  function automatic logic [7:0] step_pattern(input logic [3:0] idx);
    logic [7:0] pat;
    case (idx)
      4'd0:    pat = 8'hFE;
      4'd1:    pat = 8'hAB;
      4'd2:    pat = 8'h11;
      4'd3:    pat = 8'hF5;
      4'd4:    pat = 8'hD5;
      4'd5:    pat = 8'hF3;
      4'd6:    pat = 8'hD5;
      4'd7:    pat = 8'h09;
      4'd8:    pat = 8'hFD;
      4'd9:    pat = 8'hE3;
      4'd10:   pat = 8'h61;
      4'd11:   pat = 8'hC7;
      4'd12:   pat = 8'h61;
      4'd13:   pat = 8'hE3;
      default: pat = 8'hFF;
    endcase
    return pat;
  endfunction

  // Bus as seen by the debounce stage
  logic [7:0] seg_s;

`ifdef SEVENSEG_MON_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
    end
  end

  assign seg_s = sync2_q;
`else
  assign seg_s = seg_in;
`endif

  state_e           state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [7:0]       acc_q, acc_d;
  logic [3:0]       stable_q, stable_d;
  logic [15:0]      timer_q, timer_d;
  logic [3:0]       step_q, step_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] errs_q, errs_d;

  logic             accept;
  logic [3:0]       nxt;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    acc_d    = acc_q;
    stable_d = stable_q;
    timer_d  = timer_q;
    step_d   = step_q;
    cycles_d = cycles_q;
    errs_d   = errs_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    stall_d  = 1'b0;
    accept   = 1'b0;
    nxt      = (step_q == 4'd13) ? 4'd0 : step_q + 4'd1;

    if (sample_en) begin
      if (seg_s != cand_q) begin
        cand_d   = seg_s;
        stable_d = 4'd1;
      end else if (stable_q != StableMax) begin
        stable_d = stable_q + 4'd1;
      end

      // Accept only a pattern that has just become stable and differs from the last one
      accept = (stable_d == StableMax) && (cand_d != acc_q);

      if (accept) begin
        acc_d   = cand_d;
        timer_d = '0;
        unique case (state_q)
          StTrack: begin
            if (cand_d == step_pattern(nxt)) begin
              step_d = nxt;
              if (nxt == 4'd0) begin
                done_d = 1'b1;
                if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
              end
            end else if (cand_d == PatStart) begin
              // Generator restarted mid-sequence: legal, not a completed cycle
              step_d = 4'd0;
            end else begin
              err_d   = 1'b1;
              if (errs_q != '1) errs_d = errs_q + CNT_W'(1);
              state_d = StError;
              step_d  = 4'd0;
            end
          end
          default: begin
            if (cand_d == PatStart) begin
              state_d = StTrack;
              step_d  = 4'd0;
            end
          end
        endcase
      end else if (state_q == StTrack && step_q != 4'd0) begin
        if (timer_q >= TimeoutLast) begin
          stall_d = 1'b1;
          state_d = StIdle;
          step_d  = 4'd0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end else begin
        // Idle at step 0 is legal, so the timer is held clear there
        timer_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cand_q   <= 8'hFF;
      acc_q    <= 8'hFF;
      stable_q <= 4'd0;
      timer_q  <= '0;
      step_q   <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      stall_q  <= 1'b0;
      cycles_q <= '0;
      errs_q   <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      stable_q <= stable_d;
      timer_q  <= timer_d;
      step_q   <= step_d;
      done_q   <= done_d;
      err_q    <= err_d;
      stall_q  <= stall_d;
      cycles_q <= cycles_d;
      errs_q   <= errs_d;
    end
  end

  assign locked      = (state_q == StTrack);
  assign step_idx    = step_q;
  assign cycle_done  = done_q;
  assign seq_err     = err_q;
  assign stall       = stall_q;
  assign cycle_count = cycles_q;
  assign err_count   = errs_q;

endmodule

// File: tb/tb_sevenseg_seq_monitor.sv
// Self-checking bench for sevenseg_seq_monitor: directed scenarios plus a randomized
// walk, all checked against a sample-history reference model.
module tb_sevenseg_seq_monitor;

  localparam int unsigned Stable  = 2;
  localparam int unsigned Timeout = 64;
  localparam int unsigned CntW    = 4;
  localparam int          CntMax  = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sample_en = 1'b0;
  logic [7:0]      seg_in = 8'hFF;
  logic            locked, cycle_done, seq_err, stall;
  logic [3:0]      step_idx;
  logic [CntW-1:0] cycle_count, err_count;

  sevenseg_seq_monitor #(
    .STABLE_SAMPLES (Stable),
    .TIMEOUT_SAMPLES(Timeout),
    .CNT_W          (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .seg_in     (seg_in),
    .locked     (locked),
    .step_idx   (step_idx),
    .cycle_done (cycle_done),
    .seq_err    (seq_err),
    .stall      (stall),
    .cycle_count(cycle_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0] tbl [14] = '{8'hFE, 8'hAB, 8'h11, 8'hF5, 8'hD5, 8'hF3, 8'hD5,
                           8'h09, 8'hFD, 8'hE3, 8'h61, 8'hC7, 8'h61, 8'hE3};

  // Reference model: a pattern is accepted when the last Stable samples all match
  // it and it differs from the previously accepted pattern.
  logic [7:0] m_hist[$];
  logic [7:0] m_acc;
  int         m_mode;   // 0 idle, 1 tracking, 2 error
  int         m_step;
  int         m_since;
  int         m_cycles;
  int         m_errs;
  bit         e_done, e_err, e_stall;

  task automatic model_reset();
    m_hist.delete();
    m_acc = 8'hFF;
    m_mode = 0; m_step = 0; m_since = 0; m_cycles = 0; m_errs = 0;
    e_done = 0; e_err = 0; e_stall = 0;
  endtask

  task automatic model_strobe(input logic [7:0] v);
    bit hit;
    int nxt;
    e_done = 0; e_err = 0; e_stall = 0;
    m_hist.push_back(v);
    if (m_hist.size() > Stable) void'(m_hist.pop_front());
    hit = (m_hist.size() == Stable) && (v != m_acc);
    foreach (m_hist[i]) if (m_hist[i] != v) hit = 0;
    if (hit) begin
      m_acc = v;
      m_since = 0;
      if (m_mode == 1) begin
        nxt = (m_step + 1) % 14;
        if (v == tbl[nxt]) begin
          m_step = nxt;
          if (nxt == 0) begin
            e_done = 1;
            if (m_cycles < CntMax) m_cycles++;
          end
        end else if (v == 8'hFE) begin
          m_step = 0;
        end else begin
          e_err = 1;
          if (m_errs < CntMax) m_errs++;
          m_mode = 2;
          m_step = 0;
        end
      end else if (v == 8'hFE) begin
        m_mode = 1;
        m_step = 0;
      end
    end else if (m_mode == 1 && m_step != 0) begin
      m_since++;
      if (m_since == Timeout) begin
        e_stall = 1;
        m_mode = 0;
        m_step = 0;
        m_since = 0;
      end
    end
  endtask

  function automatic logic [15:0] exp_vec();
    return {m_mode == 1, 4'(m_step), e_done, e_err, e_stall, 4'(m_cycles), 4'(m_errs)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {locked, step_idx, cycle_done, seq_err, stall, cycle_count, err_count};
  endfunction

  // One strobe of value v; outputs are settled on return
  task automatic strobe(input logic [7:0] v);
    @(negedge clk);
    seg_in = v;
    sample_en = 1'b1;
    @(posedge clk);
    model_strobe(v);
    #1;
  endtask

  // One clk with no strobe; the bus wiggles to show it is ignored
  task automatic idle();
    @(negedge clk);
    sample_en = 1'b0;
    seg_in = 8'($urandom);
    @(posedge clk);
    e_done = 0; e_err = 0; e_stall = 0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs actual=%h required=%h", dut_vec(), 16'h0);
    end
  endtask

  task automatic test_full_cycle();
    do_reset();
    for (int s = 0; s <= 14; s++) begin
      for (int h = 0; h < 3; h++) begin
        strobe(tbl[s % 14]);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL full_cycle s=%0d h=%0d actual=%h required=%h", s, h, dut_vec(),
                   exp_vec());
        end
      end
    end
    checks++;
    if ({locked, step_idx, cycle_count, err_count} !== {1'b1, 4'd0, 4'd1, 4'd0}) begin
      fails++;
      $display("FAIL full_cycle_end actual=%h required=%h",
               {locked, step_idx, cycle_count, err_count}, {1'b1, 4'd0, 4'd1, 4'd0});
    end
  endtask

  task automatic test_seq_error();
    logic [7:0] pats [7] = '{8'hFE, 8'hAB, 8'h11, 8'hF5, 8'hD5, 8'h09, 8'hFE};
    do_reset();
    foreach (pats[p]) begin
      for (int h = 0; h < 2; h++) begin
        strobe(pats[p]);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL seq_error p=%0d h=%0d actual=%h required=%h", p, h, dut_vec(),
                   exp_vec());
        end
        if (p == 5 && h == 1) begin
          checks++;
          if ({seq_err, err_count, locked} !== {1'b1, 4'd1, 1'b0}) begin
            fails++;
            $display("FAIL seq_error_pulse actual=%b required=%b",
                     {seq_err, err_count, locked}, {1'b1, 4'd1, 1'b0});
          end
        end
      end
    end
    checks++;
    if ({locked, step_idx} !== {1'b1, 4'd0}) begin
      fail_relock: begin
        fails++;
        $display("FAIL seq_error_relock actual=%b required=%b", {locked, step_idx}, 5'b10000);
      end
    end
  endtask

  task automatic test_disable_mid();
    do_reset();
    for (int s = 0; s <= 7; s++) begin
      for (int h = 0; h < 2; h++) begin
        strobe(s == 7 ? 8'hFE : tbl[s]);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL disable_mid s=%0d h=%0d actual=%h required=%h", s, h, dut_vec(),
                   exp_vec());
        end
      end
    end
    checks++;
    if ({locked, step_idx, seq_err, cycle_done, err_count} !== {1'b1, 4'd0, 2'b00, 4'd0}) begin
      fails++;
      $display("FAIL disable_mid_end actual=%h required=%h",
               {locked, step_idx, seq_err, cycle_done, err_count}, 11'h400);
    end
  endtask

  task automatic test_stall();
    int stall_seen = 0;
    do_reset();
    for (int s = 0; s <= 1; s++) begin
      strobe(tbl[s]);
      strobe(tbl[s]);
    end
    for (int h = 0; h < Timeout + 6; h++) begin
      strobe(8'h11);
      if (stall) stall_seen++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stall h=%0d actual=%h required=%h", h, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (stall_seen !== 1 || locked !== 1'b0) begin
      fails++;
      $display("FAIL stall_once pulses=%0d locked=%b required 1 and 0", stall_seen, locked);
    end
    stall_seen = 0;
    for (int h = 0; h < 200; h++) begin
      strobe(8'hFE);
      if (stall) stall_seen++;
    end
    checks++;
    if (stall_seen !== 0 || {locked, step_idx} !== 5'b10000) begin
      fails++;
      $display("FAIL stall_step0 pulses=%0d lock_step=%b required 0 and 10000", stall_seen,
               {locked, step_idx});
    end
  endtask

  task automatic test_glitch();
    logic [7:0] pats [6] = '{8'hFE, 8'hFE, 8'hAB, 8'hFE, 8'hFE, 8'hFE};
    do_reset();
    foreach (pats[p]) begin
      strobe(pats[p]);
      checks++;
      if (dut_vec() !== exp_vec() || step_idx !== 4'd0) begin
        fails++;
        $display("FAIL glitch p=%0d actual=%h required=%h", p, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_power_up();
    logic [7:0] pats [9] = '{8'hAB, 8'hAB, 8'hAB, 8'h11, 8'h11, 8'h11, 8'hFE, 8'hFE, 8'hAB};
    do_reset();
    foreach (pats[p]) begin
      strobe(pats[p]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL power_up p=%0d actual=%h required=%h", p, dut_vec(), exp_vec());
      end
    end
    strobe(8'hAB);
    // Reset asserted between edges must clear outputs without a clock
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 16'h0) begin
      fails++;
      $display("FAIL async_reset actual=%h required=%h", dut_vec(), 16'h0);
    end
    @(negedge clk);
    sample_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < CntMax + 2; c++) begin
      for (int s = 0; s < 14; s++) begin
        strobe(tbl[s]);
        strobe(tbl[s]);
      end
    end
    strobe(8'hFE);
    strobe(8'hFE);
    checks++;
    if (dut_vec() !== exp_vec() || cycle_count !== 4'hF || cycle_done !== 1'b1) begin
      fails++;
      $display("FAIL cycle_saturate actual=%h required=%h", dut_vec(), exp_vec());
    end
    for (int e = 0; e < CntMax + 2; e++) begin
      strobe(8'h09);
      strobe(8'h09);
      strobe(8'hFE);
      strobe(8'hFE);
    end
    strobe(8'h09);
    strobe(8'h09);
    checks++;
    if (dut_vec() !== exp_vec() || err_count !== 4'hF || seq_err !== 1'b1) begin
      fails++;
      $display("FAIL err_saturate actual=%h required=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int gen = 0;
    int r, hold;
    logic [7:0] v;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      r = $urandom_range(0, 99);
      hold = $urandom_range(1, 4);
      if (r < 70) begin
        gen = (gen + 1) % 14;
        v = tbl[gen];
      end else if (r < 78) begin
        gen = 0;
        v = 8'hFE;
      end else if (r < 88) begin
        gen = $urandom_range(0, 13);
        v = tbl[gen];
      end else if (r < 95) begin
        v = 8'($urandom);
        hold = 1;
      end else if (r < 97) begin
        v = tbl[gen];
        hold = Timeout + 2;
      end else begin
        v = 8'hFF;
      end
      for (int h = 0; h < hold; h++) begin
        strobe(v);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          fails++;
          $display("FAIL random it=%0d v=%h actual=%h required=%h", it, v, dut_vec(),
                   exp_vec());
        end
        if ($urandom_range(0, 3) == 0) begin
          idle();
          checks++;
          if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL random_idle it=%0d actual=%h required=%h", it, dut_vec(),
                     exp_vec());
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_cycle();
    test_seq_error();
    test_disable_mid();
    test_stall();
    test_glitch();
    test_power_up();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
